// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared SID types, register map and write-entry struct
package sid_pkg;

    localparam int SID_DELAY_W = 16;

    typedef logic [4:0] sid_addr_t;

    localparam sid_addr_t SID_V0_FREQ_LO = 5'h00;
    localparam sid_addr_t SID_V0_FREQ_HI = 5'h01;
    localparam sid_addr_t SID_V0_PW_LO   = 5'h02;
    localparam sid_addr_t SID_V0_PW_HI   = 5'h03;
    localparam sid_addr_t SID_V0_CTRL    = 5'h04;
    localparam sid_addr_t SID_V0_AD      = 5'h05;
    localparam sid_addr_t SID_V0_SR      = 5'h06;
    localparam sid_addr_t SID_V1_FREQ_LO = 5'h07;
    localparam sid_addr_t SID_V1_FREQ_HI = 5'h08;
    localparam sid_addr_t SID_V1_PW_LO   = 5'h09;
    localparam sid_addr_t SID_V1_PW_HI   = 5'h0A;
    localparam sid_addr_t SID_V1_CTRL    = 5'h0B;
    localparam sid_addr_t SID_V1_AD      = 5'h0C;
    localparam sid_addr_t SID_V1_SR      = 5'h0D;
    localparam sid_addr_t SID_V2_FREQ_LO = 5'h0E;
    localparam sid_addr_t SID_V2_FREQ_HI = 5'h0F;
    localparam sid_addr_t SID_V2_PW_LO   = 5'h10;
    localparam sid_addr_t SID_V2_PW_HI   = 5'h11;
    localparam sid_addr_t SID_V2_CTRL    = 5'h12;
    localparam sid_addr_t SID_V2_AD      = 5'h13;
    localparam sid_addr_t SID_V2_SR      = 5'h14;
    localparam sid_addr_t SID_FC_LO      = 5'h15;
    localparam sid_addr_t SID_FC_HI      = 5'h16;
    localparam sid_addr_t SID_RES_FILT   = 5'h17;
    localparam sid_addr_t SID_MODE_VOL   = 5'h18;

    typedef struct packed {
        sid_addr_t              addr;
        logic [7:0]             data;
        logic [SID_DELAY_W-1:0] delay;
    } sid_wr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_STROBE
    } sid_wseq_state_t;

endpackage

// File: rtl/sid_wr_fifo.sv
// rtl/sid_wr_fifo.sv - synchronous write-entry FIFO with level and clear
module sid_wr_fifo
    import sid_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = sid_wr_t
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  T                       i_wdata,
    input  logic                   i_pop,
    output T                       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_level;
    logic           w_push;
    logic           w_pop;

    // Clear wins over both push and pop in the same cycle.
    assign w_push = i_push && !o_full && !i_clear;
    assign w_pop  = i_pop && !o_empty && !i_clear;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/sid_write_sequencer.sv
// rtl/sid_write_sequencer.sv - buffers timed SID register writes and replays them on clk_en
module sid_write_sequencer
    import sid_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   clk_en,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4:0]             req_addr,
    input  logic [7:0]             req_data,
    input  logic [DELAY_W-1:0]     req_delay,
    input  logic                   flush,
    output logic [4:0]             sid_addr,
    output logic [7:0]             sid_data,
    output logic                   sid_n_cs,
    output logic                   sid_rw,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    typedef struct packed {
        sid_addr_t          addr;
        logic [7:0]         data;
        logic [DELAY_W-1:0] delay;
    } wr_t;

    wr_t                w_req;
    wr_t                w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    sid_wseq_state_t    r_state;
    sid_addr_t          r_addr;
    logic [7:0]         r_data;
    logic [DELAY_W-1:0] r_cnt;

    // No bypass: a full FIFO refuses even when a pop happens this cycle.
    assign req_ready = !w_full && !flush;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty && !flush;
    assign w_req     = '{addr: req_addr, data: req_data, delay: req_delay};

    sid_wr_fifo #(
        .DEPTH (DEPTH),
        .T     (wr_t)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_wdata (w_req),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            sid_addr <= '0;
            sid_data <= '0;
            sid_n_cs <= 1'b1;
            sid_rw   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_addr  <= w_head.addr;
                        r_data  <= w_head.data;
                        r_cnt   <= w_head.delay;
                        r_state <= (w_head.delay == '0) ? ST_ISSUE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (clk_en) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == DELAY_W'(1)) r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (clk_en) begin
                        sid_addr <= r_addr;
                        sid_data <= r_data;
                        sid_n_cs <= 1'b0;
                        sid_rw   <= 1'b0;
                        r_state  <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    // A strobe already on the bus always completes, flush or not.
                    sid_n_cs <= 1'b1;
                    sid_rw   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_sid_write_sequencer.sv
// tb/tb_sid_write_sequencer.sv - self-checking bench for sid_write_sequencer
module tb_sid_write_sequencer;
    import sid_pkg::*;

    localparam int DEPTH   = 16;
    localparam int DELAY_W = 16;

    logic                   clk = 1'b0;
    logic                   n_reset;
    logic                   clk_en = 1'b0;
    logic                   req_valid;
    logic                   req_ready;
    logic [4:0]             req_addr;
    logic [7:0]             req_data;
    logic [DELAY_W-1:0]     req_delay;
    logic                   flush;
    logic [4:0]             sid_addr;
    logic [7:0]             sid_data;
    logic                   sid_n_cs;
    logic                   sid_rw;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;

    always #5 clk = ~clk;

    sid_write_sequencer #(.DEPTH(DEPTH), .DELAY_W(DELAY_W)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .clk_en    (clk_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_delay (req_delay),
        .flush     (flush),
        .sid_addr  (sid_addr),
        .sid_data  (sid_data),
        .sid_n_cs  (sid_n_cs),
        .sid_rw    (sid_rw),
        .busy      (busy),
        .level     (level)
    );

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        int         delay;
    } ent_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        int         delay;
        int         en_period;
        int         exp_ticks;
        logic [4:0] exp_addr;
        logic [7:0] exp_data;
    } vec_t;

    ent_t exp_q[$];
    int   launch_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    bit   last_en = 1'b0;
    int   en_period = 1;
    bit   en_rand = 1'b0;
    int   phase = 0;
    int   strobe_count = 0;
    int   last_strobe_en = -1000;
    logic [4:0] last_addr = '0;
    logic [7:0] last_data = '0;
    bit   prev_low = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en_rand) clk_en = ($urandom_range(2) == 0);
        else         clk_en = ((phase % en_period) == 0);
        phase++;
    end

    always @(posedge clk) begin
        cyc++;
        last_en = clk_en;
        if (clk_en) en_cnt++;
    end

    // Strobe monitor and scoreboard: every strobe must match the oldest outstanding accepted entry.
    always @(negedge clk) begin
        ent_t e;
        if (!n_reset) begin
            prev_low = 1'b0;
        end else if (!sid_n_cs) begin
            strobe_count++;
            check("strobe_on_clk_en", last_en, 1);
            check("strobe_one_cycle", prev_low, 0);
            check("strobe_rw_low", sid_rw, 0);
            check("strobe_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobe_addr", sid_addr, e.addr);
                check("strobe_data", sid_data, e.data);
                check("strobe_delay_gap", (en_cnt - last_strobe_en) >= e.delay + 1, 1);
            end
            last_strobe_en = en_cnt;
            last_addr = sid_addr;
            last_data = sid_data;
            launch_q.push_back(cyc);
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [7:0] d, input int dl,
                        output bit acc, output int lvl);
        ent_t e;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_delay = DELAY_W'(dl);
        #1;
        acc = req_ready;
        lvl = int'(level);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (acc) begin
            e.addr = a; e.data = d; e.delay = dl;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_strobes(input int target, input int limit, input string name);
        int n = 0;
        while (strobe_count < target && n < limit) begin
            tick();
            n++;
        end
        check(name, strobe_count >= target, 1);
    endtask

    task automatic drain(input int limit, input string name);
        int n = 0;
        while ((exp_q.size() > 0 || busy) && n < limit) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_level"}, level, 0);
    endtask

    vec_t vecs[6];

    initial begin
        bit acc;
        int lvl;
        int n0;
        int base;
        int accepted;
        int n;

        vecs[0] = '{SID_MODE_VOL, 8'h0F, 0, 4, 1, 5'h18, 8'h0F};
        vecs[1] = '{SID_V0_CTRL,  8'h11, 3, 4, 4, 5'h04, 8'h11};
        vecs[2] = '{5'h1F,        8'hA5, 0, 1, 1, 5'h1F, 8'hA5};
        vecs[3] = '{5'h00,        8'h5A, 2, 1, 3, 5'h00, 8'h5A};
        vecs[4] = '{5'h19,        8'h01, 1, 3, 2, 5'h19, 8'h01};
        vecs[5] = '{SID_V1_CTRL,  8'hFF, 7, 2, 8, 5'h0B, 8'hFF};

        n_reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
        req_delay = '0; flush = 1'b0;
        repeat (3) tick();
        check("rst_n_cs", sid_n_cs, 1);
        check("rst_rw", sid_rw, 1);
        check("rst_addr", sid_addr, 0);
        check("rst_data", sid_data, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        n_reset = 1'b1;
        tick();

        // Single entries into an empty queue: exact launch tick, one strobe, back to idle.
        foreach (vecs[i]) begin
            en_rand = 1'b0;
            en_period = vecs[i].en_period;
            repeat (3) tick();
            check("vec_idle_before", busy, 0);
            n0 = strobe_count;
            push(vecs[i].addr, vecs[i].data, vecs[i].delay, acc, lvl);
            check("vec_accept", acc, 1);
            check("vec_level_after_push", level, 1);
            tick();
            check("vec_level_after_pop", level, 0);
            check("vec_busy_held", busy, 1);
            base = en_cnt;
            wait_strobes(n0 + 1, 200, "vec_strobe_timeout");
            check("vec_latency_ticks", last_strobe_en - base, vecs[i].exp_ticks);
            check("vec_addr", last_addr, vecs[i].exp_addr);
            check("vec_data", last_data, vecs[i].exp_data);
            repeat (2 * vecs[i].en_period + 4) tick();
            check("vec_single_strobe", strobe_count, n0 + 1);
            check("vec_busy_after", busy, 0);
        end

        // Full: 20 offered, one held + DEPTH queued accepted.
        en_period = 4;
        n0 = strobe_count;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            push(5'(i), 8'(8'h80 + i), 5, acc, lvl);
            if (acc) accepted++;
            else check("full_ready_low_at_level", lvl, DEPTH);
        end
        check("full_accepted", accepted, DEPTH + 1);
        drain(3000, "full_drain");
        check("full_strobes", strobe_count - n0, DEPTH + 1);

        // Flush during WAIT with 5 queued.
        n0 = strobe_count;
        for (int i = 0; i < 6; i++) push(5'(i + 2), 8'(8'h40 + i), 5, acc, lvl);
        check("flush_wait_level", level, 5);
        flush = 1'b1;
        #1;
        check("flush_ready_low", req_ready, 0);
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("flush_wait_level0", level, 0);
        check("flush_wait_busy0", busy, 0);
        repeat (80) tick();
        check("flush_wait_no_strobe", strobe_count, n0);

        // Flush while the strobe is on the bus: it still completes.
        n0 = strobe_count;
        push(5'h05, 8'h21, 0, acc, lvl);
        push(5'h06, 8'h22, 0, acc, lvl);
        n = 0;
        while (sid_n_cs && n < 50) begin tick(); n++; end
        check("flush_strobe_found", sid_n_cs, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("flush_strobe_end", sid_n_cs, 1);
        check("flush_strobe_level0", level, 0);
        check("flush_strobe_busy0", busy, 0);
        repeat (30) tick();
        check("flush_strobe_count", strobe_count, n0 + 1);

        // Back-to-back throughput with clk_en every cycle: one write per 3 clocks.
        en_period = 1;
        launch_q.delete();
        n0 = strobe_count;
        for (int i = 0; i < 3; i++) push(5'(i + 8), 8'(i + 1), 0, acc, lvl);
        wait_strobes(n0 + 3, 50, "tput_timeout");
        check("tput_count", launch_q.size(), 3);
        if (launch_q.size() == 3) begin
            check("tput_gap01", launch_q[1] - launch_q[0], 3);
            check("tput_gap12", launch_q[2] - launch_q[1], 3);
        end

        // Reset during STROBE.
        en_period = 4;
        push(5'h07, 8'h33, 0, acc, lvl);
        push(5'h08, 8'h34, 0, acc, lvl);
        push(5'h09, 8'h35, 0, acc, lvl);
        n = 0;
        while (sid_n_cs && n < 50) begin tick(); n++; end
        check("rst_mid_strobe_found", sid_n_cs, 0);
        n_reset = 1'b0;
        #1;
        check("rst_mid_n_cs", sid_n_cs, 1);
        check("rst_mid_rw", sid_rw, 1);
        exp_q.delete();
        tick();
        n_reset = 1'b1;
        tick();
        check("rst_mid_level", level, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", req_ready, 1);

        // Random traffic against the scoreboard.
        en_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(2) == 0)
                push(5'($urandom_range(31)), 8'($urandom_range(255)),
                     int'($urandom_range(3)), acc, lvl);
            else
                tick();
        end
        drain(4000, "rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1);
    end

endmodule
